// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR, its period monitor and their benches.
package lfsr_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_COUNT   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Period of a maximal-length LFSR of the given width: 2^width - 1.
  function automatic longint unsigned max_period(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/lfsr_period_monitor_if.sv
// Sample stream in, measurement results out, for lfsr_period_monitor.
interface lfsr_period_monitor_if #(
  parameter int WIDTH = lfsr_pkg::DEFAULT_WIDTH
) ();

  // Handshake: sample is consumed on every rising edge where sample_valid=1;
  // there is no ready, the monitor always accepts. start is a one-cycle pulse.
  logic             start;
  logic             sample_valid;
  logic [WIDTH-1:0] sample;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   period;
  logic             maximal;
  logic             stuck;
  logic             timeout;

  modport master (
    output start, sample_valid, sample,
    input  busy, done, period, maximal, stuck, timeout
  );

  modport slave (
    input  start, sample_valid, sample,
    output busy, done, period, maximal, stuck, timeout
  );

endinterface

// File: rtl/lfsr_cycle_counter.sv
// WIDTH+1-bit sample counter with clear/enable; flags when the next count reaches 2^WIDTH.
module lfsr_cycle_counter
  import lfsr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           enable,
  output logic [WIDTH:0] count_next,
  output logic           terminal
);

  localparam logic [WIDTH:0] TERMINAL_COUNT = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH:0] count_q;

  assign count_next = count_q + {{WIDTH{1'b0}}, 1'b1};
  assign terminal   = (count_next == TERMINAL_COUNT);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_next;
    end
  end

endmodule

// File: rtl/lfsr_period_monitor.sv
// Captures a reference LFSR word, counts valid samples until it recurs and
// reports the period, or flags lock-up / no recurrence within 2^WIDTH samples.
module lfsr_period_monitor
  import lfsr_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  lfsr_period_monitor_if.slave mon,
  output state_t               state_dbg
);

  localparam logic [WIDTH:0] MAX_PERIOD = (WIDTH + 1)'(max_period(WIDTH));

  state_t           state_q;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] prev_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH:0]   period_q;
  logic             maximal_q;
  logic             stuck_q;
  logic             timeout_q;

  logic [WIDTH:0]   count_next;
  logic             terminal;
  logic             hit_ref;
  logic             hit_prev;
  logic             cnt_clear;
  logic             cnt_enable;

  assign hit_ref  = (mon.sample == ref_q);
  assign hit_prev = (mon.sample == prev_q);

  // The counter only advances on a COUNT sample that does not end the measurement.
  assign cnt_clear  = mon.start || (state_q == S_CAPTURE && mon.sample_valid);
  assign cnt_enable = !mon.start && (state_q == S_COUNT) && mon.sample_valid &&
                      !hit_ref && !hit_prev && !terminal;

  lfsr_cycle_counter #(.WIDTH(WIDTH)) u_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear),
    .enable     (cnt_enable),
    .count_next (count_next),
    .terminal   (terminal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ref_q     <= '0;
      prev_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      period_q  <= '0;
      maximal_q <= 1'b0;
      stuck_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else if (mon.start) begin
      state_q   <= S_CAPTURE;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      period_q  <= '0;
      maximal_q <= 1'b0;
      stuck_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_CAPTURE: begin
          if (mon.sample_valid) begin
            ref_q  <= mon.sample;
            prev_q <= mon.sample;
            if (mon.sample == '0) begin
              stuck_q  <= 1'b1;
              period_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (mon.sample_valid) begin
            if (hit_ref) begin
              period_q  <= count_next;
              maximal_q <= (count_next == MAX_PERIOD);
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else if (hit_prev) begin
              // Fixed point: the stream can never return to the reference.
              stuck_q  <= 1'b1;
              period_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else if (terminal) begin
              timeout_q <= 1'b1;
              period_q  <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              prev_q <= mon.sample;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mon.busy    = busy_q;
  assign mon.done    = done_q;
  assign mon.period  = period_q;
  assign mon.maximal = maximal_q;
  assign mon.stuck   = stuck_q;
  assign mon.timeout = timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed and randomized measurements of lfsr_period_monitor against a stream-level reference model.
module tb_lfsr_period_monitor;
  import lfsr_pkg::*;

  localparam int W  = 8;
  localparam int RW = W + 1 + 3;  // {period, maximal, stuck, timeout}

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  lfsr_period_monitor_if #(.WIDTH(W)) mon_if ();
  state_t state_dbg;

  lfsr_period_monitor #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .mon       (mon_if),
    .state_dbg (state_dbg)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [RW-1:0] exp_q[$];
  logic [W-1:0]  stream_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus sources ----------------
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s, input logic [W-1:0] taps);
    return {s[W-2:0], ^(s & taps)};
  endfunction

  task automatic gen_lfsr(input logic [W-1:0] taps, input logic [W-1:0] seed, input int len);
    logic [W-1:0] s;
    s = seed;
    stream_q.delete();
    repeat (len) begin
      stream_q.push_back(s);
      s = lfsr_step(s, taps);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the list of valid samples from capture onward: find the first
  // recurrence of word 0, the first adjacent repeat, and the 2^W sample limit.
  function automatic logic [RW-1:0] model(input logic [W-1:0] q[$], output int len);
    int limit, j_ref, j_fix, term;
    logic [W:0] per;
    limit = 1 << W;
    j_ref = -1;
    j_fix = -1;
    if (q[0] == '0) begin
      len = 1;
      return {{(W+1){1'b0}}, 1'b0, 1'b1, 1'b0};
    end
    for (int j = 1; j < q.size() && j <= limit; j++) begin
      if (j_ref < 0 && q[j] == q[0])   j_ref = j;
      if (j_fix < 0 && q[j] == q[j-1]) j_fix = j;
    end
    term = limit;
    if (j_fix >= 0 && j_fix < term) term = j_fix;
    if (j_ref >= 0 && j_ref <= term) begin
      len = j_ref + 1;
      per = (W+1)'(j_ref);
      return {per, (j_ref == limit - 1), 1'b0, 1'b0};
    end else if (term == j_fix) begin
      len = j_fix + 1;
      return {{(W+1){1'b0}}, 1'b0, 1'b1, 1'b0};
    end
    len = limit + 1;
    return {{(W+1){1'b0}}, 1'b0, 1'b0, 1'b1};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    mon_if.start        = 1'b1;
    mon_if.sample_valid = 1'b0;
    mon_if.sample       = W'($urandom);
    @(posedge clock); #1;
    mon_if.start = 1'b0;
  endtask

  function automatic logic [RW-1:0] result();
    return {mon_if.period, mon_if.maximal, mon_if.stuck, mon_if.timeout};
  endfunction

  // gap_mode: 0 = valid every cycle, 1 = every other cycle, 2 = random gaps.
  task automatic run(input string tag, input int gap_mode, input int abort_at,
                     input bit use_fixed, input logic [RW-1:0] fixed_exp);
    int len, idx, cycles;
    bit seen, aborted, phase, v;
    logic [RW-1:0] exp;
    idx = 0; cycles = 0; seen = 0; aborted = 0; phase = 0;
    pulse_start();
    check({tag, " busy_after_start"}, mon_if.busy, 1);
    check({tag, " done_after_start"}, mon_if.done, 0);
    exp_q.push_back(model(stream_q, len));
    while (!seen && cycles < 2000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       begin v = phase; phase = ~phase; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (idx >= stream_q.size()) v = 1'b0;
      mon_if.sample_valid = v;
      mon_if.sample       = v ? stream_q[idx] : W'($urandom);
      if (v) idx++;
      @(posedge clock); #1;
      cycles++;
      if (abort_at > 0 && !aborted && idx == abort_at) begin
        aborted = 1;
        pulse_start();
        check({tag, " busy_after_restart"}, mon_if.busy, 1);
        check({tag, " done_cleared_by_restart"}, mon_if.done, 0);
        stream_q = stream_q[idx:$];
        idx = 0;
        void'(exp_q.pop_back());
        exp_q.push_back(model(stream_q, len));
      end
      if (mon_if.done) seen = 1;
    end
    mon_if.sample_valid = 1'b0;
    check({tag, " done_within_budget"}, seen, 1);
    check({tag, " samples_consumed"}, idx, len);
    exp = exp_q.pop_front();
    check({tag, " result"}, result(), exp);
    if (use_fixed) check({tag, " result_vs_plan"}, result(), fixed_exp);
    check({tag, " busy_in_done"}, mon_if.busy, 0);
    check({tag, " state_done"}, state_dbg, S_DONE);
    repeat (3) begin
      mon_if.sample_valid = 1'b1;
      mon_if.sample       = W'($urandom);
      @(posedge clock); #1;
    end
    mon_if.sample_valid = 1'b0;
    check({tag, " done_held"}, mon_if.done, 1);
    check({tag, " result_held"}, result(), exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, mon_if.busy, 0);
    check({tag, " done"}, mon_if.done, 0);
    check({tag, " result"}, result(), 0);
    check({tag, " state"}, state_dbg, S_IDLE);
  endtask

  // ---------------- sequence ----------------
  initial begin
    logic [W-1:0] taps, seed;
    reset               = 1'b1;
    mon_if.start        = 1'b0;
    mon_if.sample_valid = 1'b0;
    mon_if.sample       = '0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Idle ignores samples without a start.
    repeat (4) begin
      mon_if.sample_valid = 1'b1;
      mon_if.sample       = W'($urandom);
      @(posedge clock); #1;
    end
    mon_if.sample_valid = 1'b0;
    check_all_zero("idle_ignores");

    gen_lfsr(8'b10111000, 8'hFF, 300);
    run("maximal", 0, 0, 1, {9'd255, 1'b1, 1'b0, 1'b0});

    gen_lfsr(8'b10000000, 8'h01, 300);
    run("rotate", 0, 0, 1, {9'd8, 1'b0, 1'b0, 1'b0});

    gen_lfsr(8'b10111000, 8'h00, 300);
    run("zero_seed", 0, 0, 1, {9'd0, 1'b0, 1'b1, 1'b0});

    stream_q.delete();
    stream_q.push_back(8'h05);
    stream_q.push_back(8'hFF);
    stream_q.push_back(8'hFF);
    run("fixed_point", 0, 0, 1, {9'd0, 1'b0, 1'b1, 1'b0});

    gen_lfsr(8'b10111000, 8'hFF, 300);
    run("gapped", 1, 0, 1, {9'd255, 1'b1, 1'b0, 1'b0});

    stream_q.delete();
    stream_q.push_back(8'h01);
    for (int i = 0; i < 300; i++) stream_q.push_back((i % 2 == 0) ? 8'h55 : 8'hAA);
    run("no_recur", 0, 0, 1, {9'd0, 1'b0, 1'b0, 1'b1});

    gen_lfsr(8'b10111000, 8'hFF, 600);
    run("abort_restart", 0, 100, 1, {9'd255, 1'b1, 1'b0, 1'b0});

    // Reset in the middle of a count.
    gen_lfsr(8'b10111000, 8'hFF, 300);
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      mon_if.sample_valid = 1'b1;
      mon_if.sample       = stream_q[i];
      @(posedge clock); #1;
    end
    check("mid_count busy", mon_if.busy, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_all_zero("mid_count_reset");
    repeat (5) begin
      mon_if.sample       = W'($urandom);
      @(posedge clock); #1;
    end
    mon_if.sample_valid = 1'b0;
    check_all_zero("after_reset_idle");

    // Randomized: random LFSRs and small-alphabet streams with random gaps.
    for (int r = 0; r < 10; r++) begin
      if (r % 2 == 0) begin
        taps = W'($urandom);
        seed = W'($urandom_range(0, 255));
        gen_lfsr(taps, seed, 300);
      end else begin
        stream_q.delete();
        repeat (300) stream_q.push_back(W'($urandom_range(0, 3)));
      end
      run($sformatf("random%0d", r), 2, 0, 0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
